regfile_wb_arbiter: RTL and testbench

// Owns the single register-file write port. Arbitrates between two requesters: the pipeline writeback stage and the quantum measurement return path.

---
 rtl/regfile_wb_arbiter_if.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: pipeline writeback request, measurement return path, regfile write port.
// Latency: none of its own; it only bundles wires (the regfile write port is registered in the arbiter).
// Backpressure: o_stall holds the pipeline request and o_mea_ready throttles measurement pushes.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 3
);
  // pipeline writeback request
  logic              i_wb_valid;
  logic [2:0]        i_wb_sel;
  logic [ADDR_W-1:0] i_wb_rd;
  logic [DATA_W-1:0] i_wb_mem;
  logic [DATA_W-1:0] i_wb_alu;
  logic [DATA_W-1:0] i_wb_comp;
  logic [DATA_W-1:0] i_wb_imm;
  logic              o_stall;

  // measurement return path
  logic              i_mea_valid;
  logic              o_mea_ready;
  logic [ADDR_W-1:0] i_mea_rd;
  logic [DATA_W-1:0] i_mea_data;
  logic [CNT_W-1:0]  o_mea_cnt;

  // register-file write port
  logic              o_rf_we;
  logic [ADDR_W-1:0] o_rf_waddr;
  logic [DATA_W-1:0] o_rf_wdata;

  // requester side: pipeline, measurement unit and regfile observer
  modport master (
    output i_wb_valid, i_wb_sel, i_wb_rd, i_wb_mem, i_wb_alu, i_wb_comp, i_wb_imm,
    output i_mea_valid, i_mea_rd, i_mea_data,
    input  o_stall, o_mea_ready, o_mea_cnt, o_rf_we, o_rf_waddr, o_rf_wdata
  );

  // arbiter side
  modport slave (
    input  i_wb_valid, i_wb_sel, i_wb_rd, i_wb_mem, i_wb_alu, i_wb_comp, i_wb_imm,
    input  i_mea_valid, i_mea_rd, i_mea_data,
    output o_stall, o_mea_ready, o_mea_cnt, o_rf_we, o_rf_waddr, o_rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single regfile write port shared by pipeline writeback and a buffered measurement return path.
// Latency: grant to o_rf_we is 1 cycle; measurement push to write is 2 cycles minimum (no bypass).
// Backpressure: o_stall when the pipeline loses arbitration; o_mea_ready drops while the FIFO is full.
`ifndef REGSRC_MEM
`define REGSRC_MEM  3'd0
`endif
`ifndef REGSRC_ALU
`define REGSRC_ALU  3'd1
`endif
`ifndef REGSRC_COMP
`define REGSRC_COMP 3'd2
`endif
`ifndef REGSRC_IMM
`define REGSRC_IMM  3'd3
`endif
`ifndef REGSRC_MEA
`define REGSRC_MEA  3'd4
`endif

module regfile_wb_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,   // power of two, >= 2, so pointers wrap naturally
  parameter int STARVE_LIMIT = 8    // >= 1
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  LAST_WIN  = SC_W'(STARVE_LIMIT - 1);

  typedef enum logic {
    ST_PIPE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t            state;
  logic [SC_W-1:0]   starve_cnt;

  logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  mea_cnt;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              mea_gnt;
  logic              pipe_gnt;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  // Occupancy is registered, so ready never depends on this cycle's grant.
  assign fifo_empty      = (mea_cnt == '0);
  assign fifo_full       = (mea_cnt == FULL_CNT);
  assign bus.o_mea_ready = !fifo_full;
  assign bus.o_mea_cnt   = mea_cnt;
  assign push            = bus.i_mea_valid && !fifo_full;

  // Measurement wins when forced by the drain state, when the FIFO is full, or when the pipeline is idle.
  assign mea_gnt     = !fifo_empty && ((state == ST_DRAIN) || fifo_full || !bus.i_wb_valid);
  assign pipe_gnt    = bus.i_wb_valid && !mea_gnt;
  assign bus.o_stall = bus.i_wb_valid && mea_gnt;

  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // Pipeline source select; unknown codes (including the measurement code) fall back to the ALU result.
  always_comb begin
    case (bus.i_wb_sel)
      `REGSRC_MEM:  wb_data = bus.i_wb_mem;
      `REGSRC_ALU:  wb_data = bus.i_wb_alu;
      `REGSRC_COMP: wb_data = bus.i_wb_comp;
      `REGSRC_IMM:  wb_data = bus.i_wb_imm;
      default:      wb_data = bus.i_wb_alu;
    endcase
  end

  // Store pushed measurements; no reset needed because occupancy gates every read of this storage.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.i_mea_rd;
      fifo_data[wr_ptr] <= bus.i_mea_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mea_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (mea_gnt) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, mea_gnt})
        2'b10:   mea_cnt <= mea_cnt + CNT_W'(1);
        2'b01:   mea_cnt <= mea_cnt - CNT_W'(1);
        default: mea_cnt <= mea_cnt;
      endcase
    end
  end

  // Anti-starvation FSM: count pipeline wins over a waiting measurement, then force one drain cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_PIPE;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_PIPE: begin
          if (mea_gnt || fifo_empty) begin
            starve_cnt <= '0;
          end else if (pipe_gnt) begin
            if (starve_cnt == LAST_WIN) begin
              state      <= ST_DRAIN;
              starve_cnt <= '0;
            end else begin
              starve_cnt <= starve_cnt + SC_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // The FIFO cannot empty while the pipeline was winning, so this cycle always pops.
          state      <= ST_PIPE;
          starve_cnt <= '0;
        end
        default: begin
          state      <= ST_PIPE;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  // Registered write port: the winner's address/data are captured; x0 writes are consumed with we low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_rf_we    <= 1'b0;
      bus.o_rf_waddr <= '0;
      bus.o_rf_wdata <= '0;
    end else if (mea_gnt) begin
      bus.o_rf_we    <= (head_rd != '0);
      bus.o_rf_waddr <= head_rd;
      bus.o_rf_wdata <= head_data;
    end else if (pipe_gnt) begin
      bus.o_rf_we    <= (bus.i_wb_rd != '0);
      bus.o_rf_waddr <= bus.i_wb_rd;
      bus.o_rf_wdata <= wb_data;
    end else begin
      bus.o_rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, multi-cycle corner sequences, randomized traffic.
// Latency: outputs sampled mid low phase; registered outputs checked one cycle after the deciding edge.
// Backpressure: pipeline stimulus is held whenever the reference model predicts a stall.
`ifndef REGSRC_MEM
`define REGSRC_MEM  3'd0
`endif
`ifndef REGSRC_ALU
`define REGSRC_ALU  3'd1
`endif
`ifndef REGSRC_COMP
`define REGSRC_COMP 3'd2
`endif
`ifndef REGSRC_IMM
`define REGSRC_IMM  3'd3
`endif
`ifndef REGSRC_MEA
`define REGSRC_MEA  3'd4
`endif

module tb_regfile_wb_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(STARVE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: measurement queue plus "pipeline wins while a measurement waits"
  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } mea_t;
  mea_t        q[$];
  int          wins = 0;
  bit          force_drain = 0;
  bit          stalled = 0;
  logic        obs_stall;
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [63:0] m_wdata = '0;

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic [63:0] mem, alu, comp, imm;
    logic        ewe;
    logic [4:0]  ewa;
    logic [63:0] ewd;
    logic        estall;
  } vec_t;
  vec_t vecs[7];

  int pw_t[3] = '{90, 50, 100};
  int pm_t[3] = '{30, 80, 15};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pick(input logic [2:0] sel, input logic [63:0] mem,
                                       input logic [63:0] alu, input logic [63:0] comp,
                                       input logic [63:0] imm);
    case (sel)
      `REGSRC_MEM:  return mem;
      `REGSRC_COMP: return comp;
      `REGSRC_IMM:  return imm;
      default:      return alu;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    wins = 0;
    force_drain = 0;
    stalled = 0;
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // Called just after a falling edge with inputs applied; checks this cycle and the resulting write.
  task automatic tick();
    int   sz;
    bit   full, mg, pg, exp_stall;
    mea_t e;
    #1;
    sz = q.size();
    full = (sz == DEPTH);
    mg = (sz != 0) && (force_drain || full || !bus.i_wb_valid);
    pg = bus.i_wb_valid && !mg;
    exp_stall = bus.i_wb_valid && mg;
    obs_stall = bus.o_stall;
    chk("stall", 64'(bus.o_stall), 64'(exp_stall));
    chk("mea_ready", 64'(bus.o_mea_ready), 64'(!full));
    chk("mea_cnt", 64'(bus.o_mea_cnt), 64'(sz));
    stalled = exp_stall;
    if (mg) begin
      e = q.pop_front();
      m_we = (e.rd != 0);
      m_waddr = e.rd;
      m_wdata = e.data;
    end else if (pg) begin
      m_we = (bus.i_wb_rd != 0);
      m_waddr = bus.i_wb_rd;
      m_wdata = pick(bus.i_wb_sel, bus.i_wb_mem, bus.i_wb_alu, bus.i_wb_comp, bus.i_wb_imm);
    end else begin
      m_we = 1'b0;
    end
    if (bus.i_mea_valid && !full) begin
      e.rd = bus.i_mea_rd;
      e.data = bus.i_mea_data;
      q.push_back(e);
    end
    if (force_drain) begin
      force_drain = 0;
      wins = 0;
    end else if (mg || sz == 0) begin
      wins = 0;
    end else if (pg) begin
      wins++;
      if (wins == STARVE) begin
        force_drain = 1;
        wins = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("rf_we", 64'(bus.o_rf_we), 64'(m_we));
    chk("rf_waddr", 64'(bus.o_rf_waddr), 64'(m_waddr));
    chk("rf_wdata", bus.o_rf_wdata, m_wdata);
  endtask

  // New pipeline request unless the previous one is still stalled and must be held.
  task automatic set_wb(input logic v, input logic [2:0] sel, input logic [4:0] rd, input logic [63:0] d);
    if (stalled) return;
    bus.i_wb_valid = v;
    bus.i_wb_sel = sel;
    bus.i_wb_rd = rd;
    bus.i_wb_mem = d ^ 64'hFFFF_0000_0000_0000;
    bus.i_wb_alu = d;
    bus.i_wb_comp = {63'd0, d[0]};
    bus.i_wb_imm = ~d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wins_cnt;
    bit got;
    logic [4:0] hrd;

    vecs[0] = '{1'b1, `REGSRC_ALU,  5'd5,  64'hA0, 64'h1234, 64'h0, 64'hB0, 1'b1, 5'd5,  64'h1234, 1'b0};
    vecs[1] = '{1'b1, `REGSRC_IMM,  5'd0,  64'hA1, 64'hA2,   64'h1, 64'hFF, 1'b0, 5'd0,  64'hFF,   1'b0};
    vecs[2] = '{1'b1, `REGSRC_MEM,  5'd31, 64'hDEAD_BEEF_0000_0001, 64'hA3, 64'h0, 64'hB3,
                1'b1, 5'd31, 64'hDEAD_BEEF_0000_0001, 1'b0};
    vecs[3] = '{1'b1, `REGSRC_COMP, 5'd3,  64'hA4, 64'hA5,   64'h1, 64'hB4, 1'b1, 5'd3,  64'h1,    1'b0};
    vecs[4] = '{1'b1, `REGSRC_MEA,  5'd9,  64'hA6, 64'h5555, 64'h0, 64'hB6, 1'b1, 5'd9,  64'h5555, 1'b0};
    vecs[5] = '{1'b1, 3'd7,         5'd10, 64'hA7, 64'h7777, 64'h1, 64'hB7, 1'b1, 5'd10, 64'h7777, 1'b0};
    vecs[6] = '{1'b0, `REGSRC_ALU,  5'd12, 64'h0,  64'h9999, 64'h0, 64'h0,  1'b0, 5'd10, 64'h7777, 1'b0};

    bus.i_wb_valid = 0; bus.i_wb_sel = '0; bus.i_wb_rd = '0;
    bus.i_wb_mem = '0; bus.i_wb_alu = '0; bus.i_wb_comp = '0; bus.i_wb_imm = '0;
    bus.i_mea_valid = 0; bus.i_mea_rd = '0; bus.i_mea_data = '0;
    model_reset();

    // reset values
    #12;
    chk("rst_we", 64'(bus.o_rf_we), 64'd0);
    chk("rst_waddr", 64'(bus.o_rf_waddr), 64'd0);
    chk("rst_wdata", bus.o_rf_wdata, 64'd0);
    chk("rst_cnt", 64'(bus.o_mea_cnt), 64'd0);
    chk("rst_ready", 64'(bus.o_mea_ready), 64'd1);
    chk("rst_stall", 64'(bus.o_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vector table: pipeline-only writes, FIFO empty
    for (int i = 0; i < 7; i++) begin
      bus.i_wb_valid = vecs[i].v;  bus.i_wb_sel = vecs[i].sel; bus.i_wb_rd = vecs[i].rd;
      bus.i_wb_mem = vecs[i].mem;  bus.i_wb_alu = vecs[i].alu;
      bus.i_wb_comp = vecs[i].comp; bus.i_wb_imm = vecs[i].imm;
      tick();
      chk($sformatf("tbl%0d_stall", i), 64'(obs_stall), 64'(vecs[i].estall));
      chk($sformatf("tbl%0d_we", i), 64'(bus.o_rf_we), 64'(vecs[i].ewe));
      chk($sformatf("tbl%0d_waddr", i), 64'(bus.o_rf_waddr), 64'(vecs[i].ewa));
      chk($sformatf("tbl%0d_wdata", i), bus.o_rf_wdata, vecs[i].ewd);
    end

    // single measurement with idle pipeline: cnt=1 next cycle, write two cycles after push
    bus.i_wb_valid = 0;
    bus.i_mea_valid = 1; bus.i_mea_rd = 5'd7; bus.i_mea_data = 64'd1;
    tick();
    chk("T3_cnt1", 64'(bus.o_mea_cnt), 64'd1);
    chk("T3_no_bypass_we", 64'(bus.o_rf_we), 64'd0);
    bus.i_mea_valid = 0;
    tick();
    chk("T3_we", 64'(bus.o_rf_we), 64'd1);
    chk("T3_waddr", 64'(bus.o_rf_waddr), 64'd7);
    chk("T3_wdata", bus.o_rf_wdata, 64'd1);
    chk("T3_cnt0", 64'(bus.o_mea_cnt), 64'd0);

    // fill the FIFO under a busy pipeline; full forces a stall and the oldest entry drains
    for (int k = 0; k < 4; k++) begin
      set_wb(1, `REGSRC_ALU, 5'(1 + k), 64'h4000 + 64'(k));
      bus.i_mea_valid = 1; bus.i_mea_rd = 5'(20 + k); bus.i_mea_data = 64'h100 + 64'(k);
      tick();
    end
    bus.i_mea_valid = 0;
    set_wb(1, `REGSRC_ALU, 5'd5, 64'h4004);
    #1;
    chk("T4_ready_full", 64'(bus.o_mea_ready), 64'd0);
    chk("T4_cnt_full", 64'(bus.o_mea_cnt), 64'd4);
    tick();
    chk("T4_stall", 64'(obs_stall), 64'd1);
    chk("T4_we", 64'(bus.o_rf_we), 64'd1);
    chk("T4_waddr", 64'(bus.o_rf_waddr), 64'd20);
    chk("T4_wdata", bus.o_rf_wdata, 64'h100);
    chk("T4_ready_again", 64'(bus.o_mea_ready), 64'd1);
    for (int k = 0; k < 12; k++) begin
      set_wb(1, `REGSRC_ALU, 5'(6 + k), 64'h4100 + 64'(k));
      tick();
    end

    // anti-starvation: one pending measurement under a permanently busy pipeline
    bus.i_wb_valid = 0;
    for (int k = 0; k < 8; k++) tick();
    chk("T5_empty_start", 64'(bus.o_mea_cnt), 64'd0);
    set_wb(1, `REGSRC_ALU, 5'd11, 64'h5000);
    bus.i_mea_valid = 1; bus.i_mea_rd = 5'd17; bus.i_mea_data = 64'hABC;
    tick();
    bus.i_mea_valid = 0;
    wins_cnt = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      set_wb(1, `REGSRC_ALU, 5'(1 + k), 64'h5100 + 64'(k));
      hrd = bus.i_wb_rd;
      tick();
      if (obs_stall) got = 1;
      else wins_cnt++;
    end
    chk("T5_drain_seen", 64'(got), 64'd1);
    chk("T5_wins", 64'(wins_cnt), 64'd8);
    chk("T5_mea_we", 64'(bus.o_rf_we), 64'd1);
    chk("T5_mea_waddr", 64'(bus.o_rf_waddr), 64'd17);
    chk("T5_mea_wdata", bus.o_rf_wdata, 64'hABC);
    set_wb(1, `REGSRC_ALU, 5'd30, 64'h5FFF);
    tick();
    chk("T5_resume_stall", 64'(obs_stall), 64'd0);
    chk("T5_resume_waddr", 64'(bus.o_rf_waddr), 64'(hrd));

    // asynchronous reset with three entries buffered
    for (int k = 0; k < 3; k++) begin
      set_wb(1, `REGSRC_ALU, 5'(2 + k), 64'h6000 + 64'(k));
      bus.i_mea_valid = 1; bus.i_mea_rd = 5'(24 + k); bus.i_mea_data = 64'h600 + 64'(k);
      tick();
    end
    bus.i_mea_valid = 0;
    bus.i_wb_valid = 0;
    chk("T6_cnt_pre", 64'(bus.o_mea_cnt), 64'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("T6_we", 64'(bus.o_rf_we), 64'd0);
    chk("T6_cnt", 64'(bus.o_mea_cnt), 64'd0);
    chk("T6_ready", 64'(bus.o_mea_ready), 64'd1);
    chk("T6_stall", 64'(bus.o_stall), 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("T6_idle_we", 64'(bus.o_rf_we), 64'd0);
    end

    // randomized traffic in three pressure phases
    for (int c = 0; c < 3000; c++) begin
      int ph;
      ph = (c / 250) % 3;
      set_wb(($urandom_range(0, 99) < pw_t[ph]), 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 31)), {$urandom(), $urandom()});
      bus.i_mea_valid = ($urandom_range(0, 99) < pm_t[ph]);
      bus.i_mea_rd = 5'($urandom_range(0, 31));
      bus.i_mea_data = {$urandom(), $urandom()};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
